fm_spy_buffer_mc: RTL and testbench
===================================

# fm_spy_buffer_mc

Multi-channel spy buffer for the fast-monitoring (FM) path: each of `N_CH` channels records a stream into a circular buffer and captures a programmable post-trigger window around a trigger. On trigger completion or software freeze the channel holds its contents for random-access readout. When frozen it can also replay the capture onto its output stream, once or looped. It sits between the user-logic monitor taps and the FM output and readout logic, replacing the fixed-mode, per-spy-buffer instances with one parametrised block.

## Interface
- `N_CH`, 4, number of independent channels
- `DATA_W`, 64, sample width
- `DEPTH`, 512, samples per channel buffer; power of two, ≥ 4; `AW = log2(DEPTH)`
- `clk_hs` in 1: the single clock for all logic.
- `rst_hs` in 1: reset, asynchronous, active-low.
- `ch_data_i` in `N_CH`×`DATA_W`: monitored sample per channel
- `ch_valid_i` in `N_CH`: sample qualifier per channel
- `arm_i` in `N_CH`: 1-cycle pulse, start recording
- `trig_i` in `N_CH`: 1-cycle pulse, trigger
- `freeze_i` in `N_CH`: forced freeze, level
- `post_trig_i` in `AW`: post-trigger sample count, shared; max `DEPTH-1`
- `pb_mode_i` in `N_CH`×2: 0 = passthrough, 1 = playback once, 2 = playback loop, 3 = reserved (treated as 0)
- `ch_data_o` out `N_CH`×`DATA_W`, `ch_valid_o` out `N_CH`: output stream per channel
- `rd_en_i` in 1, `rd_ch_i` in `clog2(N_CH)`, `rd_addr_i` in `AW`: readout request; the address is an offset from the oldest sample
- `rd_data_o` out `DATA_W`, `rd_valid_o` out 1, `rd_err_o` out 1: readout response
- `state_o` out `N_CH`×2: 0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
- `trig_ptr_o` out `N_CH`×`AW`: physical address of the trigger sample
- `count_o` out `N_CH`×(`AW`+1): number of stored samples

## Operation
- **Channel storage:** one simple dual-port RAM per channel, 1-cycle read. Each channel also holds a write pointer `wp` and a `wrapped` flag.
- **IDLE:**
  - `arm_i` → ARMED. `wp`←0 and `wrapped`←0.
  - `trig_i` and `freeze_i` are ignored.
- **ARMED:**
  - Each valid sample writes `mem[wp]`, then `wp++` modulo `DEPTH`.
  - The wrap from `DEPTH-1` to 0 sets `wrapped`.
  - `trig_i` → POST. `trig_ptr`←`wp`, the post counter ←`post_trig_i`, and a same-cycle valid sample is written as the trigger sample.
  - If `post_trig_i`=0, the channel goes straight to FROZEN after the trigger-cycle write.
- **POST:** each valid write decrements the counter. The write that reaches 0 is the final one, then → FROZEN.
- **Freeze:** `freeze_i` high in ARMED or POST → FROZEN next cycle. It has priority over `trig_i`, and a same-cycle valid sample is not written.
- **FROZEN:**
  - No writes.
  - `arm_i` → ARMED, clearing the buffer pointers and aborting playback.
- **Priority:** `arm_i` has priority over `trig_i` and `freeze_i` in every state.
- **Count:** `count` = `DEPTH` if `wrapped`, else `wp`. The oldest sample is at `wrapped ? wp : 0`.
- **Passthrough (mode 0, or not FROZEN):** `ch_data_o`/`ch_valid_o` are the inputs registered once.
- **Playback (FROZEN, mode 1/2):**
  - Sets `ch_valid_o`=0 at mode entry and emits `count` samples oldest-first, one per cycle.
  - Once: stops, outputs idle until the mode changes.
  - Loop: restarts from the oldest sample with no gap.
  - `count`=0: emits nothing.
  - Mode change to 0 aborts immediately; change between 1 and 2 takes effect at the next pass.
- **Readout:**
  - Reads physical address `(oldest + rd_addr_i) mod DEPTH` of channel `rd_ch_i`.
  - `rd_ch_i` not FROZEN, or `rd_addr_i` ≥ `count` → `rd_err_o`=1 with `rd_data_o`=0.
  - The readout port has priority over playback on the same channel RAM. Playback stalls that cycle: `ch_valid_o`=0 and the sequence does not advance.

## Timing
- **Reset values:** all outputs 0, all channels IDLE, `wp`=0, `wrapped`=0. Asserting reset mid-operation discards the capture; RAM contents are undefined.
- **State update:** `state_o` updates the cycle after the causing input.
- **Passthrough latency:** 1 cycle.
- **Playback latency:** first `ch_valid_o` 2 cycles after entry to FROZEN with mode ≠ 0, or after a mode change from 0.
- **Readout latency:** `rd_en_i` at cycle t → `rd_valid_o` pulse with data/err at t+2. Back-to-back requests are accepted every cycle.
- **Status:** `trig_ptr_o` and `count_o` are registered and valid from the cycle `state_o` shows POST/FROZEN.
- **Widths:** post counter `AW` bits, `count` `AW`+1 bits, address arithmetic modulo `DEPTH`.

## Test plan
- **Pre-wrap capture:** `DEPTH`=16, arm ch0, 5 valid samples 0..4, trig with sample 5, `post_trig_i`=3, samples 6..8 → FROZEN after sample 8. `count_o`=9, `trig_ptr_o`=5, readout of addr 0..8 returns 0..8, addr 9 gives `rd_err_o`.
- **Wrapped capture:** 40 samples 0..39, trig on sample 30, `post_trig_i`=9 → `count_o`=16, readout of addr 0 = 24, addr 15 = 39.
- **Forced freeze:** `freeze_i` and `trig_i` in the same ARMED cycle → FROZEN with no trigger. The valid sample that cycle is not stored, and `trig_ptr_o` is unchanged.
- **Playback:**
  - Frozen with count 4, mode 1 → `ch_valid_o` for 4 cycles starting 2 cycles after entry, oldest-first, then idle.
  - Mode 2 → continuous repetition.
  - A readout hitting the same channel stalls the stream by exactly one cycle per read.
- **Corner cases:**
  - Arm and trig in the same IDLE cycle → ARMED only.
  - `post_trig_i`=0 → FROZEN the cycle after the trigger.
  - Reset during POST → all outputs 0, state IDLE.
- **Channel independence:** ch1 and ch3 are armed and triggered at different times with different data → no cross-channel effect in `count_o`, readout or playback.

Source files
------------

// File: rtl/fm_spy_buffer_mc.sv
// fm_spy_buffer_mc: multi-channel spy buffer for the fast-monitoring path.
// Each channel records a stream into a circular RAM, captures a post-trigger
// window, freezes for random-access readout and can replay its capture onto
// the output stream, once or looped.
module fm_spy_buffer_mc #(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 512,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_hs,
    input  logic                     rst_hs,
    input  logic [N_CH*DATA_W-1:0]   ch_data_i,
    input  logic [N_CH-1:0]          ch_valid_i,
    input  logic [N_CH-1:0]          arm_i,
    input  logic [N_CH-1:0]          trig_i,
    input  logic [N_CH-1:0]          freeze_i,
    input  logic [AW-1:0]            post_trig_i,
    input  logic [N_CH*2-1:0]        pb_mode_i,
    output logic [N_CH*DATA_W-1:0]   ch_data_o,
    output logic [N_CH-1:0]          ch_valid_o,
    input  logic                     rd_en_i,
    input  logic [CW-1:0]            rd_ch_i,
    input  logic [AW-1:0]            rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_valid_o,
    output logic                     rd_err_o,
    output logic [N_CH*2-1:0]        state_o,
    output logic [N_CH*AW-1:0]       trig_ptr_o,
    output logic [N_CH*(AW+1)-1:0]   count_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    // Per-channel RAM read data and frozen flags, gathered for the readout mux
    logic [N_CH*DATA_W-1:0] ram_q_all;
    logic [N_CH-1:0]        frozen_vec;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        state_t            state_q, state_d;
        logic [AW-1:0]     wp_q, wp_d;
        logic              wrapped_q, wrapped_d;
        logic [AW-1:0]     trig_ptr_q, trig_ptr_d;
        logic [AW-1:0]     post_cnt_q, post_cnt_d;
        logic [AW:0]       count_q, count_d;
        logic              we;

        logic [DATA_W-1:0] din;
        logic              vin;
        logic              arm;
        logic              trig;
        logic              frz;
        logic [1:0]        mode;

        logic              pb_on;
        logic              stall;
        logic              issue;
        logic              pb_rd_q, pb_rd_d;
        logic              pb_done_q, pb_done_d;
        logic [AW:0]       pb_idx_q, pb_idx_d;
        logic [AW-1:0]     oldest;
        logic [AW-1:0]     raddr;
        logic [DATA_W-1:0] ram_q;
        logic [DATA_W-1:0] out_data_q, out_data_d;
        logic              out_valid_q, out_valid_d;

        logic [DATA_W-1:0] mem [DEPTH];

        assign din  = ch_data_i[gi*DATA_W +: DATA_W];
        assign vin  = ch_valid_i[gi];
        assign arm  = arm_i[gi];
        assign trig = trig_i[gi];
        assign frz  = freeze_i[gi];
        assign mode = pb_mode_i[gi*2 +: 2];

        // Oldest stored sample: after a wrap the next write slot holds it
        assign oldest = wrapped_q ? wp_q : '0;
        // Playback only runs while frozen with mode 1 or 2; mode 3 acts as passthrough
        assign pb_on  = (state_q == ST_FROZEN) && ((mode == 2'd1) || (mode == 2'd2));
        // A readout of this channel takes the RAM read port for the cycle
        assign stall  = rd_en_i && (rd_ch_i == CW'(gi));
        assign raddr  = stall ? (oldest + rd_addr_i) : (oldest + pb_idx_q[AW-1:0]);

        // Capture control: arm, record, trigger, post window and freeze
        always_comb begin
            state_d    = state_q;
            wp_d       = wp_q;
            wrapped_d  = wrapped_q;
            trig_ptr_d = trig_ptr_q;
            post_cnt_d = post_cnt_q;
            we         = 1'b0;
            if (arm) begin
                state_d   = ST_ARMED;
                wp_d      = '0;
                wrapped_d = 1'b0;
            end else begin
                case (state_q)
                    ST_ARMED, ST_POST: begin
                        if (frz) begin
                            state_d = ST_FROZEN;
                        end else begin
                            we = vin;
                            if (vin) begin
                                wp_d = wp_q + AW'(1);
                                if (&wp_q) begin
                                    wrapped_d = 1'b1;
                                end
                            end
                            if (state_q == ST_ARMED) begin
                                if (trig) begin
                                    trig_ptr_d = wp_q;
                                    post_cnt_d = post_trig_i;
                                    state_d    = (post_trig_i == '0) ? ST_FROZEN : ST_POST;
                                end
                            end else if (vin) begin
                                post_cnt_d = post_cnt_q - AW'(1);
                                if (post_cnt_q == AW'(1)) begin
                                    state_d = ST_FROZEN;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
            count_d = wrapped_d ? {1'b1, {AW{1'b0}}} : {1'b0, wp_d};
        end

        // Playback sequencer and output stream select
        always_comb begin
            pb_idx_d  = pb_idx_q;
            pb_done_d = pb_done_q;
            issue     = 1'b0;
            if (!pb_on) begin
                pb_idx_d  = '0;
                pb_done_d = 1'b0;
            end else if ((count_q != '0) && !(pb_done_q && (mode == 2'd1)) && !stall) begin
                issue = 1'b1;
                if (pb_idx_q == count_q - (AW+1)'(1)) begin
                    pb_idx_d  = '0;
                    pb_done_d = (mode == 2'd1);
                end else begin
                    pb_idx_d = pb_idx_q + (AW+1)'(1);
                end
            end
            pb_rd_d = issue;
            if (pb_on) begin
                out_valid_d = pb_rd_q;
                out_data_d  = pb_rd_q ? ram_q : '0;
            end else begin
                out_valid_d = vin;
                out_data_d  = din;
            end
        end

        // Channel RAM: write at the write pointer, registered read
        always_ff @(posedge clk_hs) begin
            if (we) begin
                mem[wp_q] <= din;
            end
            ram_q <= mem[raddr];
        end

        // Channel state and output registers
        always_ff @(posedge clk_hs or negedge rst_hs) begin
            if (!rst_hs) begin
                state_q     <= ST_IDLE;
                wp_q        <= '0;
                wrapped_q   <= 1'b0;
                trig_ptr_q  <= '0;
                post_cnt_q  <= '0;
                count_q     <= '0;
                pb_rd_q     <= 1'b0;
                pb_done_q   <= 1'b0;
                pb_idx_q    <= '0;
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                wp_q        <= wp_d;
                wrapped_q   <= wrapped_d;
                trig_ptr_q  <= trig_ptr_d;
                post_cnt_q  <= post_cnt_d;
                count_q     <= count_d;
                pb_rd_q     <= pb_rd_d;
                pb_done_q   <= pb_done_d;
                pb_idx_q    <= pb_idx_d;
                out_data_q  <= out_data_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign ram_q_all[gi*DATA_W +: DATA_W]   = ram_q;
        assign frozen_vec[gi]                   = (state_q == ST_FROZEN);
        assign ch_data_o[gi*DATA_W +: DATA_W]   = out_data_q;
        assign ch_valid_o[gi]                   = out_valid_q;
        assign state_o[gi*2 +: 2]               = state_q;
        assign trig_ptr_o[gi*AW +: AW]          = trig_ptr_q;
        assign count_o[gi*(AW+1) +: (AW+1)]     = count_q;
    end

    // Readout pipeline: stage 1 tracks the RAM access, stage 2 drives the response
    logic              rd_v1_q, rd_v1_d;
    logic              rd_err1_q, rd_err1_d;
    logic [CW-1:0]     rd_ch1_q, rd_ch1_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Readout error check and response formatting
    always_comb begin
        rd_v1_d   = rd_en_i;
        rd_ch1_d  = rd_ch_i;
        rd_err1_d = !frozen_vec[rd_ch_i] ||
                    ({1'b0, rd_addr_i} >= count_o[rd_ch_i*(AW+1) +: (AW+1)]);
        rd_valid_d = rd_v1_q;
        rd_err_d   = rd_v1_q && rd_err1_q;
        rd_data_d  = (rd_v1_q && !rd_err1_q) ? ram_q_all[rd_ch1_q*DATA_W +: DATA_W] : '0;
    end

    // Readout pipeline registers
    always_ff @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            rd_v1_q    <= 1'b0;
            rd_err1_q  <= 1'b0;
            rd_ch1_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_v1_q    <= rd_v1_d;
            rd_err1_q  <= rd_err1_d;
            rd_ch1_q   <= rd_ch1_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_fm_spy_buffer_mc.sv
// Directed, table-driven bench for fm_spy_buffer_mc (4 channels, 16-deep buffers).
module tb_fm_spy_buffer_mc;

    localparam int N_CH  = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 2;

    logic                  clk_hs = 1'b0;
    logic                  rst_hs;
    logic [N_CH*DW-1:0]    ch_data_i;
    logic [N_CH-1:0]       ch_valid_i;
    logic [N_CH-1:0]       arm_i;
    logic [N_CH-1:0]       trig_i;
    logic [N_CH-1:0]       freeze_i;
    logic [AW-1:0]         post_trig_i;
    logic [N_CH*2-1:0]     pb_mode_i;
    logic [N_CH*DW-1:0]    ch_data_o;
    logic [N_CH-1:0]       ch_valid_o;
    logic                  rd_en_i;
    logic [CW-1:0]         rd_ch_i;
    logic [AW-1:0]         rd_addr_i;
    logic [DW-1:0]         rd_data_o;
    logic                  rd_valid_o;
    logic                  rd_err_o;
    logic [N_CH*2-1:0]     state_o;
    logic [N_CH*AW-1:0]    trig_ptr_o;
    logic [N_CH*(AW+1)-1:0] count_o;

    fm_spy_buffer_mc #(.N_CH(N_CH), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs),
        .ch_data_i(ch_data_i), .ch_valid_i(ch_valid_i),
        .arm_i(arm_i), .trig_i(trig_i), .freeze_i(freeze_i),
        .post_trig_i(post_trig_i), .pb_mode_i(pb_mode_i),
        .ch_data_o(ch_data_o), .ch_valid_o(ch_valid_o),
        .rd_en_i(rd_en_i), .rd_ch_i(rd_ch_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_err_o(rd_err_o),
        .state_o(state_o), .trig_ptr_o(trig_ptr_o), .count_o(count_o)
    );

    always #5 clk_hs = ~clk_hs;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          arm;
        logic          trig;
        logic          frz;
        logic          vld;
        logic [DW-1:0] data;
        logic [AW-1:0] post;
        logic [1:0]    exp_state;
        logic [AW:0]   exp_count;
    } vec_t;

    vec_t vecs[13];
    int   exp_pb[14];

    function automatic vec_t mk(input logic a, input logic t, input logic f, input logic v,
                                input int d, input int p, input int es, input int ec);
        vec_t r;
        r.arm = a; r.trig = t; r.frz = f; r.vld = v;
        r.data = DW'(d); r.post = AW'(p); r.exp_state = 2'(es); r.exp_count = (AW+1)'(ec);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk_hs);
        #1;
    endtask

    function automatic logic [1:0] st(input int ch);
        return state_o[ch*2 +: 2];
    endfunction
    function automatic logic [AW:0] cnt(input int ch);
        return count_o[ch*(AW+1) +: (AW+1)];
    endfunction
    function automatic logic [AW-1:0] tp(input int ch);
        return trig_ptr_o[ch*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] od(input int ch);
        return ch_data_o[ch*DW +: DW];
    endfunction

    task automatic clear_pulses();
        arm_i      = '0;
        trig_i     = '0;
        ch_valid_i = '0;
        ch_data_i  = '0;
    endtask

    task automatic drive(input int ch, input logic vld, input logic [DW-1:0] d);
        ch_valid_i[ch]       = vld;
        ch_data_i[ch*DW +: DW] = d;
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        pb_mode_i[ch*2 +: 2] = m;
    endtask

    // Single readout: nothing at t+1, response at t+2
    task automatic do_read(input string name, input int ch, input int addr,
                           input logic exp_err, input logic [DW-1:0] exp_data);
        rd_en_i   = 1'b1;
        rd_ch_i   = CW'(ch);
        rd_addr_i = AW'(addr);
        tick();
        rd_en_i = 1'b0;
        check({name, ".early"}, 64'(rd_valid_o), 64'd0);
        tick();
        check({name, ".valid"}, 64'(rd_valid_o), 64'd1);
        check({name, ".err"},   64'(rd_err_o),   64'(exp_err));
        check({name, ".data"},  64'(rd_data_o),  64'(exp_data));
    endtask

    initial begin
        rst_hs = 1'b0;
        clear_pulses();
        freeze_i    = '0;
        post_trig_i = '0;
        pb_mode_i   = '0;
        rd_en_i     = 1'b0;
        rd_ch_i     = '0;
        rd_addr_i   = '0;

        // Pre-wrap capture on ch0, starting with arm+trig in the same IDLE cycle
        vecs[0]  = mk(1, 1, 0, 0, 0,  3, 1, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0,  3, 1, 1);
        vecs[2]  = mk(0, 0, 0, 1, 1,  3, 1, 2);
        vecs[3]  = mk(0, 0, 0, 1, 2,  3, 1, 3);
        vecs[4]  = mk(0, 0, 0, 1, 3,  3, 1, 4);
        vecs[5]  = mk(0, 0, 0, 1, 4,  3, 1, 5);
        vecs[6]  = mk(0, 1, 0, 1, 5,  3, 2, 6);
        vecs[7]  = mk(0, 0, 0, 1, 6,  3, 2, 7);
        vecs[8]  = mk(0, 0, 0, 0, 99, 3, 2, 7);
        vecs[9]  = mk(0, 0, 0, 1, 7,  3, 2, 8);
        vecs[10] = mk(0, 0, 0, 1, 8,  3, 3, 9);
        vecs[11] = mk(0, 0, 0, 1, 9,  3, 3, 9);
        vecs[12] = mk(0, 1, 0, 1, 10, 3, 3, 9);

        // Loop playback of 100..103 with one readout stall issued at j=5
        exp_pb = '{-1, 100, 101, 102, 103, 100, -1, 101, 102, 103, 100, 101, 102, 103};

        tick();
        tick();
        #2 rst_hs = 1'b1;
        tick();
        check("reset.state",    64'(state_o),    64'd0);
        check("reset.count",    64'(count_o),    64'd0);
        check("reset.trig_ptr", 64'(trig_ptr_o), 64'd0);
        check("reset.ch_valid", 64'(ch_valid_o), 64'd0);
        check("reset.rd_valid", 64'(rd_valid_o), 64'd0);

        for (int i = 0; i < 13; i++) begin
            arm_i[0]    = vecs[i].arm;
            trig_i[0]   = vecs[i].trig;
            freeze_i[0] = vecs[i].frz;
            post_trig_i = vecs[i].post;
            drive(0, vecs[i].vld, vecs[i].data);
            tick();
            clear_pulses();
            freeze_i = '0;
            check($sformatf("prewrap[%0d].state", i), 64'(st(0)),  64'(vecs[i].exp_state));
            check($sformatf("prewrap[%0d].count", i), 64'(cnt(0)), 64'(vecs[i].exp_count));
        end
        check("prewrap.trig_ptr", 64'(tp(0)), 64'd5);

        // Back-to-back readout of addr 0..9; addr 9 is past the stored count
        for (int i = 0; i < 11; i++) begin
            if (i < 10) begin
                rd_en_i = 1'b1; rd_ch_i = '0; rd_addr_i = AW'(i);
            end else begin
                rd_en_i = 1'b0;
            end
            tick();
            if (i >= 1) begin
                check($sformatf("prewrap.rd[%0d].valid", i-1), 64'(rd_valid_o), 64'd1);
                check($sformatf("prewrap.rd[%0d].err", i-1),   64'(rd_err_o),   64'(i-1 == 9));
                check($sformatf("prewrap.rd[%0d].data", i-1),  64'(rd_data_o),  (i-1 < 9) ? 64'(i-1) : 64'd0);
            end
        end
        rd_en_i = 1'b0;
        do_read("idle_ch2.rd", 2, 0, 1'b1, 16'd0);

        // Wrapped capture on ch0: samples 0..39, trigger on 30, 9 post samples
        arm_i[0] = 1'b1;
        tick();
        clear_pulses();
        check("wrap.armed", 64'(st(0)), 64'd1);
        check("wrap.count0", 64'(cnt(0)), 64'd0);
        for (int i = 0; i < 40; i++) begin
            drive(0, 1'b1, DW'(i));
            trig_i[0]   = (i == 30);
            post_trig_i = AW'(9);
            tick();
            clear_pulses();
            if (i == 38) check("wrap.post_before_last", 64'(st(0)), 64'd2);
            if (i == 39) check("wrap.frozen", 64'(st(0)), 64'd3);
        end
        check("wrap.count",    64'(cnt(0)), 64'd16);
        check("wrap.trig_ptr", 64'(tp(0)),  64'd14);
        do_read("wrap.rd0",  0, 0,  1'b0, 16'd24);
        do_read("wrap.rd15", 0, 15, 1'b0, 16'd39);
        do_read("wrap.rd5",  0, 5,  1'b0, 16'd29);

        // Forced freeze with a same-cycle trigger and sample; playback once armed up
        arm_i[0] = 1'b1;
        tick();
        clear_pulses();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, DW'(100 + i));
            tick();
            clear_pulses();
        end
        freeze_i[0] = 1'b1;
        trig_i[0]   = 1'b1;
        post_trig_i = AW'(2);
        drive(0, 1'b1, 16'd104);
        set_mode(0, 2'd1);
        tick();
        clear_pulses();
        freeze_i = '0;
        check("freeze.state",    64'(st(0)),  64'd3);
        check("freeze.count",    64'(cnt(0)), 64'd4);
        check("freeze.trig_ptr", 64'(tp(0)),  64'd14);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k >= 2 && k <= 5) begin
                check($sformatf("pb_once[%0d].valid", k), 64'(ch_valid_o[0]), 64'd1);
                check($sformatf("pb_once[%0d].data", k),  64'(od(0)),         64'(100 + k - 2));
            end else begin
                check($sformatf("pb_once[%0d].valid", k), 64'(ch_valid_o[0]), 64'd0);
            end
        end
        set_mode(0, 2'd0);
        tick();
        do_read("freeze.rd3", 0, 3, 1'b0, 16'd103);
        do_read("freeze.rd4", 0, 4, 1'b1, 16'd0);

        // Loop playback with a same-channel readout stalling one cycle
        for (int j = 0; j < 14; j++) begin
            if (j == 0) set_mode(0, 2'd2);
            rd_en_i   = (j == 5);
            rd_ch_i   = '0;
            rd_addr_i = AW'(1);
            tick();
            if (exp_pb[j] < 0) begin
                check($sformatf("pb_loop[%0d].valid", j), 64'(ch_valid_o[0]), 64'd0);
            end else begin
                check($sformatf("pb_loop[%0d].valid", j), 64'(ch_valid_o[0]), 64'd1);
                check($sformatf("pb_loop[%0d].data", j),  64'(od(0)),         64'(exp_pb[j]));
            end
            if (j == 6) begin
                check("pb_loop.rd.valid", 64'(rd_valid_o), 64'd1);
                check("pb_loop.rd.data",  64'(rd_data_o),  64'd101);
            end
        end
        rd_en_i = 1'b0;

        // Mode change to 0 returns to passthrough immediately
        set_mode(0, 2'd0);
        drive(0, 1'b1, 16'h5555);
        tick();
        clear_pulses();
        check("abort.valid", 64'(ch_valid_o[0]), 64'd1);
        check("abort.data",  64'(od(0)),         64'h5555);

        // post_trig_i = 0: frozen the cycle after the trigger
        arm_i[0] = 1'b1;
        tick();
        clear_pulses();
        drive(0, 1'b1, 16'h0077);
        trig_i[0]   = 1'b1;
        post_trig_i = '0;
        tick();
        clear_pulses();
        check("post0.state",    64'(st(0)),  64'd3);
        check("post0.count",    64'(cnt(0)), 64'd1);
        check("post0.trig_ptr", 64'(tp(0)),  64'd0);
        do_read("post0.rd0", 0, 0, 1'b0, 16'h0077);

        // Empty capture: playback emits nothing
        arm_i[2] = 1'b1;
        tick();
        clear_pulses();
        freeze_i[2] = 1'b1;
        tick();
        freeze_i = '0;
        check("empty.state", 64'(st(2)),  64'd3);
        check("empty.count", 64'(cnt(2)), 64'd0);
        set_mode(2, 2'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("empty.pb[%0d].valid", k), 64'(ch_valid_o[2]), 64'd0);
        end
        set_mode(2, 2'd0);

        // Channel independence: ch1 then ch3 with different data and timing
        arm_i[1] = 1'b1;
        tick();
        clear_pulses();
        drive(1, 1'b1, 16'h1100);
        drive(3, 1'b1, 16'h3300);
        tick();
        clear_pulses();
        drive(1, 1'b1, 16'h1101);
        tick();
        clear_pulses();
        drive(1, 1'b1, 16'h1102);
        trig_i[1]   = 1'b1;
        post_trig_i = AW'(1);
        tick();
        clear_pulses();
        check("ind.ch1.post", 64'(st(1)), 64'd2);
        drive(1, 1'b1, 16'h1103);
        tick();
        clear_pulses();
        check("ind.ch1.state",    64'(st(1)),  64'd3);
        check("ind.ch1.count",    64'(cnt(1)), 64'd4);
        check("ind.ch1.trig_ptr", 64'(tp(1)),  64'd2);
        check("ind.ch3.idle",     64'(st(3)),  64'd0);
        check("ind.ch3.count0",   64'(cnt(3)), 64'd0);
        arm_i[3] = 1'b1;
        tick();
        clear_pulses();
        for (int i = 0; i < 9; i++) begin
            drive(3, 1'b1, DW'(16'h3300 + i));
            drive(1, 1'b1, DW'(16'h11F0 + i));
            trig_i[3]   = (i == 6);
            post_trig_i = AW'(2);
            tick();
            clear_pulses();
        end
        check("ind.ch3.state",    64'(st(3)),  64'd3);
        check("ind.ch3.count",    64'(cnt(3)), 64'd9);
        check("ind.ch3.trig_ptr", 64'(tp(3)),  64'd6);
        check("ind.ch1.count2",   64'(cnt(1)), 64'd4);
        check("ind.ch1.trig_ptr2", 64'(tp(1)), 64'd2);
        check("ind.ch0.count",    64'(cnt(0)), 64'd1);
        do_read("ind.ch1.rd3", 1, 3, 1'b0, 16'h1103);
        do_read("ind.ch1.rd4", 1, 4, 1'b1, 16'h0000);
        do_read("ind.ch3.rd0", 3, 0, 1'b0, 16'h3300);
        do_read("ind.ch3.rd8", 3, 8, 1'b0, 16'h3308);
        set_mode(3, 2'd1);
        drive(1, 1'b1, 16'h1ABC);
        tick();
        clear_pulses();
        check("ind.ch1.pass.valid", 64'(ch_valid_o[1]), 64'd1);
        check("ind.ch1.pass.data",  64'(od(1)),         64'h1ABC);
        check("ind.ch3.pb0.valid",  64'(ch_valid_o[3]), 64'd0);
        tick();
        check("ind.ch3.pb1.valid",  64'(ch_valid_o[3]), 64'd1);
        check("ind.ch3.pb1.data",   64'(od(3)),         64'h3300);
        check("ind.ch1.pass2.valid", 64'(ch_valid_o[1]), 64'd0);
        tick();
        check("ind.ch3.pb2.data",   64'(od(3)),         64'h3301);
        set_mode(3, 2'd0);

        // Reset asserted while ch2 is in POST
        arm_i[2] = 1'b1;
        tick();
        clear_pulses();
        drive(2, 1'b1, 16'h00AA);
        trig_i[2]   = 1'b1;
        post_trig_i = AW'(5);
        tick();
        clear_pulses();
        check("rstpost.post", 64'(st(2)), 64'd2);
        drive(1, 1'b1, 16'h1234);
        tick();
        check("rstpost.pre_valid", 64'(ch_valid_o[1]), 64'd1);
        #2 rst_hs = 1'b0;
        #1;
        check("rstpost.state",    64'(state_o),    64'd0);
        check("rstpost.count",    64'(count_o),    64'd0);
        check("rstpost.trig_ptr", 64'(trig_ptr_o), 64'd0);
        check("rstpost.ch_valid", 64'(ch_valid_o), 64'd0);
        check("rstpost.ch_data",  64'(ch_data_o != '0), 64'd0);
        check("rstpost.rd",       64'({rd_valid_o, rd_err_o, rd_data_o}), 64'd0);
        clear_pulses();
        @(posedge clk_hs);
        #3 rst_hs = 1'b1;
        tick();
        check("rstpost.after.state", 64'(state_o), 64'd0);
        check("rstpost.after.count", 64'(count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
